// File: rtl/uart_arb_pkg.sv
// Shared definitions for uart_tx_arbiter: FSM state codes, default ID prefix base,
// and the burst counter width helper.
package uart_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_PREFIX = 2'd1;
  localparam state_t S_XFER   = 2'd2;

  localparam logic [7:0] DEFAULT_ID_BASE = 8'hF0;

  // The counter only has to reach MAX_BURST-1; the grant ends on the transfer that would hit it.
  function automatic int unsigned cnt_width(input int unsigned max_burst);
    return (max_burst < 2) ? 1 : $clog2(max_burst);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte streams, UART TX byte port and arbiter status in one bundle.
// master: the arbiter; slave: the clients and UART around it.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [IdxW-1:0]      grant_id;
  logic                 busy;
  logic                 burst_trunc;

  modport master (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant_id, busy, burst_trunc
  );

  modport slave (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, grant_id, busy, burst_trunc
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after i_ptr, wrapping
// back to the lowest index when none is found above the pointer.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_valid
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [IdxW-1:0] w_hi_idx;
  logic [IdxW-1:0] w_lo_idx;
  logic            w_hi_valid;

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_hi_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_lo_idx = IdxW'(i);
        if (IdxW'(i) >= i_ptr) begin
          w_hi_idx   = IdxW'(i);
          w_hi_valid = 1'b1;
        end
      end
    end
  end

  assign o_idx   = w_hi_valid ? w_hi_idx : w_lo_idx;
  assign o_valid = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-locked sharing of one UART TX byte port among NUM_REQ requesters.
// Define UART_ARB_ID_PREFIX_EN to send an ID_BASE+grantee prefix byte at the start of each grant.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 16,
  parameter logic [7:0]  ID_BASE   = DEFAULT_ID_BASE
) (
  input logic               clk,
  input logic               rst_n,
  uart_tx_arbiter_if.master bus
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = cnt_width(MAX_BURST);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IdxW-1:0] r_grant_id;
  logic [IdxW-1:0] w_grant_nxt;
  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] w_ptr_nxt;
  logic [IdxW-1:0] w_sel_idx;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;
  logic            r_trunc;
  logic            w_trunc_nxt;
  logic            w_sel_valid;
  logic            w_gnt_valid;
  logic            w_gnt_last;
  logic [7:0]      w_gnt_data;
  logic            w_xfer;
  logic            w_cnt_hit;
  logic            w_end;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_idx   (w_sel_idx),
    .o_valid (w_sel_valid)
  );

  assign w_gnt_valid = bus.req_valid[r_grant_id];
  assign w_gnt_last  = bus.req_last[r_grant_id];
  assign w_gnt_data  = bus.req_data[{r_grant_id, 3'b000} +: 8];

  assign w_xfer    = (r_state == S_XFER) && w_gnt_valid && bus.tx_ready;
  assign w_cnt_hit = (r_cnt == CntW'(MAX_BURST - 1));
  assign w_end     = w_xfer && (w_gnt_last || w_cnt_hit);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_id;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_trunc_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sel_valid) begin
          w_grant_nxt = w_sel_idx;
`ifdef UART_ARB_ID_PREFIX_EN
          w_state_nxt = S_PREFIX;
`else
          w_state_nxt = S_XFER;
`endif
        end
      end
`ifdef UART_ARB_ID_PREFIX_EN
      S_PREFIX: begin
        if (bus.tx_ready) w_state_nxt = S_XFER;
      end
`endif
      S_XFER: begin
        if (w_end) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = (r_grant_id == IdxW'(NUM_REQ - 1)) ? '0 : r_grant_id + IdxW'(1);
          // A last byte landing exactly on the limit is a normal end.
          w_trunc_nxt = !w_gnt_last;
        end else if (w_xfer) begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.tx_valid  = 1'b0;
    bus.tx_data   = 8'h00;
    bus.req_ready = '0;
    case (r_state)
`ifdef UART_ARB_ID_PREFIX_EN
      S_PREFIX: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = ID_BASE + 8'(r_grant_id);
      end
`endif
      S_XFER: begin
        bus.tx_valid              = w_gnt_valid;
        bus.tx_data               = w_gnt_data;
        bus.req_ready[r_grant_id] = bus.tx_ready;
      end
      default: ;
    endcase
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.grant_id    = r_grant_id;
  assign bus.burst_trunc = r_trunc;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state    <= S_IDLE;
      r_grant_id <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_trunc    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant_id <= w_grant_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_trunc    <= w_trunc_nxt;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (byte-wide tx_data/tx_valid/tx_ready) between NUM_REQ byte-stream requesters.
- Grants are round-robin and burst-locked: a grantee keeps the transmitter until it flags the last byte or hits MAX_BURST bytes.
- Sits between client producers (debug log, status reporter, command responder) and the uart TX input.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before forced release (1..255).
- ID_BASE, 8'hF0, ID prefix byte base; the prefix byte is ID_BASE + requester index (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*8  packed bytes; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of requester burst.
- req_ready  out  NUM_REQ  per-requester accept.
- tx_data  out  8  byte to UART TX.
- tx_valid  out  1  byte valid to UART TX.
- tx_ready  in  1  UART TX can accept a byte.
- grant_id  out  $clog2(NUM_REQ)  current/last grantee index.
- busy  out  1  a grant is active.
- burst_trunc  out  1  one-cycle pulse when a grant ends by MAX_BURST without req_last.

Behaviour:
- Reset (rst_n=1, async): state IDLE; tx_valid=0, tx_data=0, req_ready=0, grant_id=0, busy=0, burst_trunc=0, byte counter=0. RR pointer=0, so requester 0 has top priority first.
- FSM states: IDLE, (PREFIX), XFER.
- IDLE:
  - If any req_valid, select the first requester at or after the pointer (cyclic).
  - Register grant_id, set busy, enter XFER (or PREFIX when the feature is enabled). Grant latency is 1 cycle.
  - No selection when all req_valid=0.
- XFER:
  - tx_valid = req_valid[grant_id]; tx_data = grantee's byte.
  - req_ready[grant_id] = tx_ready; every other req_ready = 0.
  - This path is combinational, so no extra latency per byte.
  - A transfer is tx_valid && tx_ready; each transfer increments the counter.
- Grant end: on the transfer with req_last=1, or the transfer that makes counter==MAX_BURST.
  - Return to IDLE; busy drops next cycle; counter clears; pointer becomes grant_id+1 mod NUM_REQ.
  - If the end was forced by MAX_BURST without req_last, pulse burst_trunc for 1 cycle.
  - A truncated requester re-arbitrates later; its remaining bytes go in a subsequent grant.
- Grantee drops req_valid mid-burst: grant is held, tx_valid=0; no timeout.
- Simultaneous requests: strict RR order. With all four requesting continuously and pointer 0, grants go 0,1,2,3,0.
- req_last and MAX_BURST on the same byte: normal end, no burst_trunc.
- tx_ready low (UART busy shifting): the byte is held stable; the requester must keep data and valid stable until ready.
- Reset mid-burst: immediate return to reset values. The byte already taken by the UART finishes independently; untaken requester bytes are not consumed.
- grant_id holds its last value while in IDLE.

Optional Feature:
- Macro: UART_ARB_ID_PREFIX_EN.
- Defined:
  - Adds state PREFIX after IDLE: tx_valid=1, tx_data=ID_BASE+grant_id, all req_ready=0.
  - Moves to XFER on tx_ready.
  - The prefix byte does not count toward MAX_BURST.
  - Lets the host demultiplex streams.
- Undefined: PREFIX state and its logic are absent; IDLE goes directly to XFER.

Decomposition:
- Package uart_arb_pkg: FSM state enum (IDLE, PREFIX, XFER), default ID_BASE constant, counter width localparam helper.
- One natural sub-module: rr_arbiter (request vector plus pointer in, one-hot/index grant out; combinational priority rotate). Instantiated once.
- FSM, counter and muxing stay in uart_tx_arbiter.

Test Plan:
- Single requester: req 1 sends 8'hA5, 8'h3C, 8'h55 (last on 8'h55), tx_ready always 1 -> tx sees A5,3C,55 on consecutive cycles; grant_id=1; busy falls 1 cycle after 55 accepted.
- Contention: reqs 0 and 2 each send a 2-byte burst simultaneously from reset -> order 0,0,2,2; no interleaving; pointer ends at 3.
- Truncation: MAX_BURST=4, req 3 streams 6 bytes with last on byte 6 -> bytes 1–4, burst_trunc pulse, re-grant to 3 (sole requester) delivers bytes 5–6, no second pulse.
- Backpressure: tx_ready toggled 1 cycle high / 9 low while req 0 sends 8'hFF, 8'h00 -> each byte held stable until accepted; req_ready mirrors tx_ready only for grantee.
- Reset mid-burst: assert rst_n during the 2nd of 4 bytes -> next cycle tx_valid=0, busy=0, grant_id=0; after release, req 2 requesting alone is granted first.
- UART_ARB_ID_PREFIX_EN defined: req 2 sends 8'h3C with last -> tx sees 8'hF2 then 8'h3C; a MAX_BURST=1 run still forwards exactly one data byte per grant.
